hdlc_rx_deframer: RTL

Receive-side HDLC deframer that sits directly behind the serial bit interface of the HDLC path. It sequences the bit-level flag/stuff/abort classification into frame-level control. It removes stuffed zeros, assembles LSB-first bytes and emits them with start-of-frame marking. It reports end-of-frame with length and error status, and reports aborts.

---
 rtl/hdlc_rx_deframer_pkg.sv | 22 ++
 rtl/hdlc_rx_deframer_if.sv | 30 +++
 rtl/hdlc_rx_deframer_classifier.sv | 50 +++++
 rtl/hdlc_rx_deframer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/hdlc_rx_deframer_pkg.sv
// Shared types and constants for the HDLC receive deframer slice.
// Holds the FSM state, the per-bit classification and the flag/stuff thresholds.
package hdlc_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    FRAME
  } state_t;

  typedef enum logic [1:0] {
    DATA,
    STUFF,
    FLAG,
    ABORT
  } bit_class_t;

  localparam logic [7:0] HDLC_FLAG  = 8'h7E;
  localparam int unsigned ONES_STUFF = 5;
  localparam int unsigned ONES_FLAG  = 6;

endpackage

// File: rtl/hdlc_rx_deframer_if.sv
// Serial bit input and byte/frame output bundle of the HDLC receive deframer.
// The slave modport is the deframer side; the master modport is the bit source / consumer side.
interface hdlc_rx_deframer_if #(
  parameter int unsigned CNT_W = 16
);

  logic             bit_valid;
  logic             bit_in;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_sof;
  logic             frame_end;
  logic             frame_err;
  logic [CNT_W-1:0] frame_len;
  logic             frame_abort;
  logic             in_frame;

  modport master (
    output bit_valid, bit_in,
    input  byte_data, byte_valid, byte_sof, frame_end, frame_err, frame_len,
           frame_abort, in_frame
  );

  modport slave (
    input  bit_valid, bit_in,
    output byte_data, byte_valid, byte_sof, frame_end, frame_err, frame_len,
           frame_abort, in_frame
  );

endinterface

// File: rtl/hdlc_rx_deframer_classifier.sv
// Ones-run counter and flag/stuff/abort classification of each valid line bit.
// The class is decided from the run length before the current bit updates it.
module hdlc_bit_classifier
  import hdlc_pkg::*;
(
  input  logic       clk,
  input  logic       areset_n,
  input  logic       bit_valid_i,
  input  logic       bit_i,
  output logic       class_valid_o,
  output bit_class_t class_o
);

  logic [2:0] ones_q;
  logic [2:0] ones_d;

  // Run length saturates at 7 so long idle-ones periods stay classified as DATA.
  always_comb begin
    ones_d = ones_q;
    if (bit_valid_i) begin
      if (!bit_i) begin
        ones_d = 3'd0;
      end else if (ones_q != 3'd7) begin
        ones_d = ones_q + 3'd1;
      end
    end
  end

  always_comb begin
    class_o = DATA;
    if (!bit_i && (ones_q == 3'(ONES_STUFF))) begin
      class_o = STUFF;
    end else if (!bit_i && (ones_q == 3'(ONES_FLAG))) begin
      class_o = FLAG;
    end else if (bit_i && (ones_q == 3'(ONES_FLAG))) begin
      class_o = ABORT;
    end
  end

  assign class_valid_o = bit_valid_i;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ones_q <= 3'd0;
    end else begin
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: hunts for flags, strips stuffed zeros, assembles LSB-first
// bytes and reports frame end (length/error) and aborts.
module hdlc_rx_deframer
  import hdlc_pkg::*;
#(
  parameter int unsigned MIN_BYTES = 2,
  parameter int unsigned CNT_W     = 16
) (
  input logic               clk,
  input logic               areset_n,
  hdlc_rx_deframer_if.slave rx
);

  bit_class_t       cls;
  logic             cls_valid;

  state_t           state_q;
  logic [6:0]       dl_q;
  logic [2:0]       dl_cnt_q;
  logic [6:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic [CNT_W-1:0] byte_cnt_q;

  logic [7:0]       byte_data_q;
  logic             byte_valid_q;
  logic             byte_sof_q;
  logic             frame_end_q;
  logic             frame_err_q;
  logic [CNT_W-1:0] frame_len_q;
  logic             frame_abort_q;
  logic             in_frame_q;

  logic             push;
  logic             commit;
  logic [7:0]       byte_d;
  logic [CNT_W-1:0] byte_cnt_d;

  hdlc_bit_classifier u_classifier (
    .clk           (clk),
    .areset_n      (areset_n),
    .bit_valid_i   (rx.bit_valid),
    .bit_i         (rx.bit_in),
    .class_valid_o (cls_valid),
    .class_o       (cls)
  );

  // Seven bits of delay keep the flag pattern out of the assembler; only the oldest bit commits.
  always_comb begin
    push       = cls_valid && (cls == DATA) && (state_q != HUNT);
    commit     = push && (dl_cnt_q == 3'd7);
    byte_d     = {dl_q[6], shift_q};
    byte_cnt_d = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= HUNT;
      dl_q          <= 7'd0;
      dl_cnt_q      <= 3'd0;
      shift_q       <= 7'd0;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= '0;
      byte_data_q   <= 8'd0;
      byte_valid_q  <= 1'b0;
      byte_sof_q    <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_len_q   <= '0;
      frame_abort_q <= 1'b0;
      in_frame_q    <= 1'b0;
    end else begin
      byte_valid_q  <= 1'b0;
      byte_sof_q    <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_abort_q <= 1'b0;

      if (push) begin
        dl_q <= {dl_q[5:0], rx.bit_in};
        if (!commit) begin
          dl_cnt_q <= dl_cnt_q + 3'd1;
        end
      end

      if (commit) begin
        shift_q   <= byte_d[7:1];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_data_q  <= byte_d;
          byte_valid_q <= 1'b1;
          byte_sof_q   <= (byte_cnt_q == '0);
          byte_cnt_q   <= byte_cnt_d;
        end
      end

      // Commit never coincides with FLAG/ABORT, so the counter clears below cannot collide with it.
      if (cls_valid) begin
        case (state_q)
          HUNT: begin
            if (cls == FLAG) begin
              state_q <= SYNC;
            end
          end
          SYNC: begin
            if (cls == FLAG) begin
              dl_cnt_q <= 3'd0;
            end else if (cls == ABORT) begin
              dl_cnt_q <= 3'd0;
              state_q  <= HUNT;
            end else if (commit) begin
              state_q    <= FRAME;
              in_frame_q <= 1'b1;
            end
          end
          FRAME: begin
            if (cls == FLAG) begin
              frame_end_q <= 1'b1;
              frame_len_q <= byte_cnt_q;
              frame_err_q <= (bit_cnt_q != 3'd0) || (byte_cnt_q < CNT_W'(MIN_BYTES));
              bit_cnt_q   <= 3'd0;
              byte_cnt_q  <= '0;
              dl_cnt_q    <= 3'd0;
              state_q     <= SYNC;
              in_frame_q  <= 1'b0;
            end else if (cls == ABORT) begin
              frame_abort_q <= 1'b1;
              bit_cnt_q     <= 3'd0;
              byte_cnt_q    <= '0;
              dl_cnt_q      <= 3'd0;
              state_q       <= HUNT;
              in_frame_q    <= 1'b0;
            end
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end
    end
  end

  assign rx.byte_data   = byte_data_q;
  assign rx.byte_valid  = byte_valid_q;
  assign rx.byte_sof    = byte_sof_q;
  assign rx.frame_end   = frame_end_q;
  assign rx.frame_err   = frame_err_q;
  assign rx.frame_len   = frame_len_q;
  assign rx.frame_abort = frame_abort_q;
  assign rx.in_frame    = in_frame_q;

endmodule
